golomb_rice_sched: RTL and testbench

GOLOMB_RICE_SCHED -- requirements
Module: golomb_rice_sched

---
 rtl/golomb_pkg.sv | 15 +
 rtl/golomb_rice_sched_enc.sv | 32 +++
 rtl/golomb_rice_sched.sv | 147 ++++++++++++++
 tb/tb_golomb_rice_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/golomb_pkg.sv
// Shared constants and FSM state type for the Golomb-Rice scheduler.
// Escape threshold/length and default clamps live here.
package golomb_pkg;

   localparam int ESC_Q    = 16;
   localparam int ESC_LEN  = 33;
   localparam int KMAX_DEF = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      EMIT = 2'd2
   } state_t;

endpackage

// File: rtl/golomb_rice_sched_enc.sv
// Combinational Rice encoder: quotient, codeword, length, escape.
// All shifts and masks are done at 32 bits.
module rice_encode
   import golomb_pkg::*;
(
   input  logic [15:0] v,
   input  logic [2:0]  k,
   output logic [31:0] q,
   output logic [31:0] code,
   output logic [5:0]  len,
   output logic        escape
);

   logic [31:0] w_v32;
   logic [31:0] w_mask;

   // quotient, escape decision and codeword/length selection
   always_comb begin
      w_v32  = {16'd0, v};
      q      = w_v32 >> k;
      escape = (q >= 32'(ESC_Q));
      w_mask = (32'd1 << k) - 32'd1;
      if (escape) begin
         code = (32'd1 << ESC_Q) | w_v32;
         len  = 6'(ESC_LEN);
      end else begin
         code = (32'd1 << k) | (w_v32 & w_mask);
         len  = 6'(q[3:0]) + 6'd1 + 6'(k);
      end
   end

endmodule

// File: rtl/golomb_rice_sched.sv
// Golomb-Rice scheduler: accepts one value, codes it, emits it.
// Adapts k per block and tracks block position.
module golomb_rice_sched
   import golomb_pkg::*;
#(
   parameter int BLOCK_LEN = 64,
   parameter int K_INIT    = 2,
   parameter int KMAX      = KMAX_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_val,
   input  logic        in_first,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_code,
   output logic [5:0]  out_len,
   output logic        out_last,
   output logic [2:0]  k_cur,
   output logic        blk_err
);

   localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_LEN - 1);
   localparam logic [2:0]    K0 = 3'(K_INIT);
   localparam logic [2:0]    KM = 3'(KMAX);

   state_t r_state;
   state_t w_next;

   logic [15:0]   r_val;
   logic          r_first;
   logic [2:0]    r_k;
   logic [CW-1:0] r_cnt;
   logic          r_up;
   logic          r_dn;
   logic [31:0]   r_code;
   logic [5:0]    r_len;
   logic          r_last;
   logic          r_err;

   logic          w_acc;
   logic          w_hs;
   logic [2:0]    w_k;
   logic [CW-1:0] w_idx;
   logic [31:0]   w_q;
   logic [31:0]   w_code;
   logic [5:0]    w_len;
   logic          w_esc;

   assign w_acc = in_valid && in_ready;
   assign w_hs  = out_valid && out_ready;
   assign w_k   = r_first ? K0 : r_k;
   assign w_idx = r_first ? '0 : r_cnt;

   rice_encode u_enc (
      .v      (r_val),
      .k      (w_k),
      .q      (w_q),
      .code   (w_code),
      .len    (w_len),
      .escape (w_esc)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // next-state and handshake outputs
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = CALC;
         end
         CALC: w_next = EMIT;
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // capture the accepted value
   always_ff @(posedge clk) begin
      if (reset) begin
         r_val   <= '0;
         r_first <= 1'b0;
      end else if (w_acc) begin
         r_val   <= in_val;
         r_first <= in_first;
      end
   end

   // codeword registers, block position, k adaptation, error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_code <= '0;
         r_len  <= '0;
         r_last <= 1'b0;
         r_cnt  <= '0;
         r_k    <= K0;
         r_up   <= 1'b0;
         r_dn   <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         if (r_state == CALC) begin
            r_code <= w_code;
            r_len  <= w_len;
            r_last <= (w_idx == LAST_IDX);
            r_cnt  <= w_idx;
            r_k    <= w_k;
            r_up   <= w_esc || (w_q >= 32'd2);
            r_dn   <= (r_val == 16'd0);
            if (r_first && (r_cnt != '0)) r_err <= 1'b1;
         end
         if (w_hs) begin
            if (r_last) begin
               r_cnt <= '0;
               r_k   <= K0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
               if (r_dn) begin
                  if (r_k != 3'd0) r_k <= r_k - 3'd1;
               end else if (r_up && (r_k < KM)) begin
                  r_k <= r_k + 3'd1;
               end
            end
         end
      end
   end

   assign out_code = r_code;
   assign out_len  = r_len;
   assign out_last = r_last;
   assign k_cur    = r_k;
   assign blk_err  = r_err;

endmodule

// File: tb/tb_golomb_rice_sched.sv
// Randomised bench for golomb_rice_sched with an arithmetic model.
// Directed block/error/reset scenarios plus a random stream.
module tb_golomb_rice_sched;

   localparam int BLK  = 64;
   localparam int KI   = 2;
   localparam int KMX  = 7;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_val;
   logic        in_first;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_code;
   logic [5:0]  out_len;
   logic        out_last;
   logic [2:0]  k_cur;
   logic        blk_err;

   int nvec;
   int nerr;
   int mk;
   int mcnt;
   int merr;
   logic [31:0] cap_code;
   logic [31:0] cap_len;

   golomb_rice_sched #(
      .BLOCK_LEN (BLK),
      .K_INIT    (KI),
      .KMAX      (KMX)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_val    (in_val),
      .in_first  (in_first),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_len   (out_len),
      .out_last  (out_last),
      .k_cur     (k_cur),
      .blk_err   (blk_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mk   = KI;
      mcnt = 0;
      merr = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   function automatic logic [15:0] rnd_val();
      case ($urandom_range(0, 3))
         0:       return 16'($urandom_range(0, 3));
         1:       return 16'($urandom_range(0, 40));
         2:       return 16'($urandom_range(0, 600));
         default: return 16'($urandom & 32'hFFFF);
      endcase
   endfunction

   // one full transaction, called at a negedge
   task automatic send(input logic [15:0] v, input logic f,
                       input int stall);
      int vi;
      int q;
      int n;
      logic [31:0] ec;
      int el;
      logic elast;
      vi = int'(v);
      if (f) begin
         if (mcnt != 0) merr = 1;
         mcnt = 0;
         mk   = KI;
      end
      q = vi >> mk;
      if (q < 16) begin
         ec = 32'((1 << mk) + (vi % (1 << mk)));
         el = q + 1 + mk;
      end else begin
         ec = 32'(65536 + vi);
         el = 33;
      end
      elast = (mcnt == BLK - 1);
      n = 0;
      while (!in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      in_val    = v;
      in_first  = f;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b0;
      chk("ov_calc", 32'(out_valid), 32'd0);
      chk("ir_calc", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_code", out_code, ec);
      chk("out_len", 32'(out_len), 32'(el));
      chk("out_last", 32'(out_last), 32'(elast));
      chk("k_applied", 32'(k_cur), 32'(mk));
      cap_code = out_code;
      cap_len  = 32'(out_len);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_code", out_code, ec);
         chk("stall_len", 32'(out_len), 32'(el));
         chk("stall_last", 32'(out_last), 32'(elast));
         chk("stall_ir", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (elast) begin
         mcnt = 0;
         mk   = KI;
      end else begin
         mcnt++;
         if (vi == 0)     mk = (mk > 0) ? mk - 1 : 0;
         else if (q >= 2) mk = (mk < KMX) ? mk + 1 : KMX;
      end
      chk("ov_after", 32'(out_valid), 32'd0);
      chk("ir_after", 32'(in_ready), 32'd1);
      chk("k_next", 32'(k_cur), 32'(mk));
      chk("blk_err", 32'(blk_err), 32'(merr));
   endtask

   initial begin
      nvec      = 0;
      nerr      = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_val    = '0;
      in_first  = 1'b0;
      out_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_ir", 32'(in_ready), 32'd1);
      chk("rst_code", out_code, 32'd0);
      chk("rst_len", 32'(out_len), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_k", 32'(k_cur), 32'd2);
      chk("rst_err", 32'(blk_err), 32'd0);

      send(16'd5, 1'b1, 0);
      chk("v5_code", cap_code, 32'd5);
      chk("v5_len", cap_len, 32'd4);
      chk("v5_k", 32'(k_cur), 32'd2);
      send(16'd0, 1'b0, 0);
      chk("v0_code", cap_code, 32'd4);
      chk("v0_len", cap_len, 32'd3);
      chk("v0_k", 32'(k_cur), 32'd1);
      repeat (3) send(16'd0, 1'b0, 0);
      chk("zero_clamp", 32'(k_cur), 32'd0);
      send(16'd3, 1'b0, 0);
      chk("v3_code", cap_code, 32'd1);
      chk("v3_len", cap_len, 32'd4);

      do_reset();
      send(16'd100, 1'b1, 0);
      chk("esc_code", cap_code, 32'h10064);
      chk("esc_len", cap_len, 32'd33);
      chk("esc_k", 32'(k_cur), 32'd3);
      repeat (8) send(16'd60000, 1'b0, 0);
      chk("kmax_clamp", 32'(k_cur), 32'd7);

      do_reset();
      for (int i = 0; i < BLK; i++)
         send(rnd_val(), (i == 0), (i == 20) ? 5 : 0);
      chk("blk_k", 32'(k_cur), 32'd2);
      chk("blk_noerr", 32'(blk_err), 32'd0);

      for (int i = 0; i < 9; i++) send(rnd_val(), (i == 0), 0);
      send(rnd_val(), 1'b1, 0);
      chk("mid_first_err", 32'(blk_err), 32'd1);
      for (int i = 1; i < BLK; i++) send(rnd_val(), 1'b0, 0);
      chk("restart_k", 32'(k_cur), 32'd2);

      in_valid = 1'b1;
      in_val   = 16'd7;
      in_first = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_ov", 32'(out_valid), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("emit_rst_ov", 32'(out_valid), 32'd0);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      chk("emit_rst_ov2", 32'(out_valid), 32'd0);
      chk("emit_rst_ir", 32'(in_ready), 32'd1);
      chk("emit_rst_err", 32'(blk_err), 32'd0);
      for (int i = 0; i < BLK; i++) send(rnd_val(), 1'b0, 0);

      for (int i = 0; i < 300; i++)
         send(rnd_val(), ($urandom_range(0, 29) == 0),
              $urandom_range(0, 2));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
